// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source interrupt controller driving the CP0 hardware interrupt lines.
// Fixed priority (source 0 highest), per-source edge/level capture, non-preemptive grant/ack/EOI flow.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  src_irq,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        cpu_ack,
    output logic [5:0]  hwint,
    output logic [1:0]  irq_id
);
    localparam logic [1:0] ADDR_PEND  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_MODE  = 2'd2;
    localparam logic [1:0] ADDR_CLAIM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] id_q, id_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] mode_q, mode_d;
    logic [3:0] src_q;

    logic       wr_pend, wr_mask, wr_mode, wr_eoi;
    logic       eoi_taken;
    logic [3:0] set_pend, clr_pend;
    logic [3:0] active;
    logic [1:0] win_id;
    logic [3:0] grant_oh;
    logic [1:0] state_bits;
    logic       wdata_unused;

    assign wr_pend   = we && (addr == ADDR_PEND);
    assign wr_mask   = we && (addr == ADDR_MASK);
    assign wr_mode   = we && (addr == ADDR_MODE);
    assign wr_eoi    = we && (addr == ADDR_CLAIM);
    assign eoi_taken = wr_eoi && (state_q == ST_SERVICE);

    assign wdata_unused = ^wdata[31:4];

    // A fresh capture in the same cycle as a W1C or EOI clear keeps the bit pending.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            assign set_pend[gi] = mode_q[gi] ? (src_irq[gi] & ~src_q[gi]) : src_irq[gi];
            assign clr_pend[gi] = (wr_pend & wdata[gi]) | (eoi_taken && (id_q == 2'(gi)));
            assign pend_d[gi]   = set_pend[gi] | (pend_q[gi] & ~clr_pend[gi]);
        end
    endgenerate

    assign mask_d = wr_mask ? wdata[3:0] : mask_q;
    assign mode_d = wr_mode ? wdata[3:0] : mode_q;
    assign active = pend_q & mask_q;

    always_comb begin
        win_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) begin
                win_id = 2'(i);
            end
        end
    end

    // ASSERT looks at next-cycle MASK/PEND so a withdrawn request drops hwint on the following edge.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    state_d = ST_ASSERT;
                    id_d    = win_id;
                end
            end
            ST_ASSERT: begin
                if (!mask_d[id_q] || !pend_d[id_q]) begin
                    state_d = ST_IDLE;
                end else if (cpu_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= 2'd0;
            pend_q  <= 4'd0;
            mask_q  <= 4'd0;
            mode_q  <= 4'd0;
            src_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            src_q   <= src_irq;
        end
    end

    assign grant_oh   = 4'b0001 << id_q;
    assign hwint      = (state_q == ST_ASSERT) ? {grant_oh, 2'b00} : 6'd0;
    assign irq_id     = (state_q == ST_IDLE) ? 2'd0 : id_q;
    assign state_bits = state_q;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_PEND:  rdata = {28'd0, pend_q};
            ADDR_MASK:  rdata = {28'd0, mask_q};
            ADDR_MODE:  rdata = {28'd0, mode_q};
            ADDR_CLAIM: rdata = {28'd0, state_bits, irq_id};
            default:    rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cpu_ack;
    logic [5:0]  hwint;
    logic [1:0]  irq_id;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .cpu_ack (cpu_ack),
        .hwint   (hwint),
        .irq_id  (irq_id)
    );

    // Model state: m_state 0 = idle, 1 = interrupt asserted, 2 = in service.
    int       m_state;
    int       m_id;
    bit [3:0] m_pend, m_mask, m_mode, m_prev;

    int vectors     = 0;
    int miscompares = 0;
    int checks      = 0;
    bit chk_en      = 0;

    function automatic void model_step();
        bit [3:0] np, nm, nd;
        int pick;
        if (reset) begin
            m_state = 0; m_id = 0;
            m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0;
            return;
        end
        np = m_pend;
        if (we && addr == 2'd0) np = np & ~wdata[3:0];
        if (we && addr == 2'd3 && m_state == 2) np[m_id] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_mode[i] ? (src_irq[i] && !m_prev[i]) : src_irq[i]) np[i] = 1'b1;
        end
        nm = (we && addr == 2'd1) ? wdata[3:0] : m_mask;
        nd = (we && addr == 2'd2) ? wdata[3:0] : m_mode;
        case (m_state)
            0: begin
                pick = -1;
                for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) pick = i;
                if (pick >= 0) begin m_state = 1; m_id = pick; end
            end
            1: begin
                if (!nm[m_id] || !np[m_id]) m_state = 0;
                else if (cpu_ack) m_state = 2;
            end
            default: if (we && addr == 2'd3) m_state = 0;
        endcase
        m_pend = np; m_mask = nm; m_mode = nd; m_prev = src_irq;
    endfunction

    function automatic logic [5:0] exp_hwint();
        return (m_state == 1) ? 6'(1 << (m_id + 2)) : 6'd0;
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_state == 0) ? 2'd0 : 2'(m_id);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_pend};
            2'd1:    return {28'd0, m_mask};
            2'd2:    return {28'd0, m_mode};
            default: return 32'(m_state * 4 + ((m_state == 0) ? 0 : m_id));
        endcase
    endfunction

    // Compare process: one time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (chk_en) begin
            checks += 3;
            if (hwint !== exp_hwint()) begin
                miscompares++;
                $display("FAIL hwint vec=%0d got=%b expected=%b", vectors, hwint, exp_hwint());
            end
            if (irq_id !== exp_id()) begin
                miscompares++;
                $display("FAIL irq_id vec=%0d got=%0d expected=%0d", vectors, irq_id, exp_id());
            end
            if (rdata !== exp_rdata(addr)) begin
                miscompares++;
                $display("FAIL rdata vec=%0d addr=%0d got=%h expected=%h", vectors, addr, rdata, exp_rdata(addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        vectors++;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic peek(input logic [1:0] a);
        we = 1'b0; addr = a; cpu_ack = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d; cpu_ack = 1'b0;
        $display("wr addr=%0d data=%h", a, d);
        tick();
        we = 1'b0;
    endtask

    task automatic ack();
        we = 1'b0; cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    initial begin
        src_irq = 4'd0; we = 1'b0; addr = 2'd0; wdata = 32'd0; cpu_ack = 1'b0; reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        peek(3); lit("reset_claim", rdata, 32'h0); lit("reset_hwint", 32'(hwint), 32'h0);
        lit("reset_id", 32'(irq_id), 32'h0);
        tick(); peek(0); lit("reset_pend", rdata, 32'h0);
        tick(); peek(1); lit("reset_mask", rdata, 32'h0);
        tick(); peek(2); lit("reset_mode", rdata, 32'h0);

        // Level source held: grant two edges later
        wr(1, 32'hF);
        src_irq = 4'b0100; tick(); tick();
        lit("lvl_hwint", 32'(hwint), 32'h10); lit("lvl_id", 32'(irq_id), 32'h2);
        src_irq = 4'b0000; ack();
        peek(3); lit("lvl_service", rdata, 32'hA); lit("lvl_service_hwint", 32'(hwint), 32'h0);
        wr(3, 32'h0);
        peek(0); lit("lvl_pend_clear", rdata, 32'h0);

        // Two pends at once: priority then re-arbitration after EOI
        src_irq = 4'b1010; tick(); src_irq = 4'b0000;
        peek(0); lit("prio_pend", rdata, 32'hA);
        tick();
        lit("prio_id1", 32'(irq_id), 32'h1); lit("prio_hwint1", 32'(hwint), 32'h08);
        ack(); wr(3, 32'h0);
        peek(0); lit("prio_pend_after_eoi", rdata, 32'h8); lit("prio_gap_hwint", 32'(hwint), 32'h0);
        lit("prio_gap_id", 32'(irq_id), 32'h0);
        tick();
        lit("prio_id3", 32'(irq_id), 32'h3); lit("prio_hwint3", 32'(hwint), 32'h20);
        ack(); wr(3, 32'h0);

        // Edge source single pulse
        wr(2, 32'h1);
        src_irq = 4'b0001; tick(); src_irq = 4'b0000;
        peek(0); lit("edge_pend", rdata, 32'h1);
        tick();
        lit("edge_hwint", 32'(hwint), 32'h04); lit("edge_id", 32'(irq_id), 32'h0);
        ack(); wr(3, 32'h0);
        tick(); peek(3); lit("edge_idle", rdata, 32'h0);
        tick(); peek(0); lit("edge_pend_clear", rdata, 32'h0);

        // Mask withdrawn while asserted
        wr(2, 32'h0);
        src_irq = 4'b0100; tick(); tick();
        lit("mask_drop_on", 32'(hwint), 32'h10);
        wr(1, 32'h0);
        lit("mask_drop_off", 32'(hwint), 32'h0);
        peek(3); lit("mask_drop_state", rdata, 32'h0);
        tick(); peek(0); lit("mask_drop_pend", rdata, 32'h4);
        src_irq = 4'b0000; wr(0, 32'hF); wr(1, 32'hF);

        // EOI coinciding with a new edge on the serviced source
        wr(2, 32'h1);
        src_irq = 4'b0001; tick(); src_irq = 4'b0000; tick();
        ack();
        src_irq = 4'b0001; wr(3, 32'h0); src_irq = 4'b0000;
        peek(0); lit("eoi_race_pend", rdata, 32'h1); lit("eoi_race_gap", 32'(hwint), 32'h0);
        tick();
        lit("eoi_race_regrant", 32'(hwint), 32'h04);
        peek(3); lit("eoi_race_claim", rdata, 32'h4);
        ack(); wr(3, 32'h0);

        // Reset while in service
        src_irq = 4'b0001; tick(); src_irq = 4'b0000; tick(); ack();
        peek(3); lit("rst_pre_claim", rdata, 32'h8);
        reset = 1'b1; tick(); reset = 1'b0;
        peek(3); lit("rst_claim", rdata, 32'h0); lit("rst_hwint", 32'(hwint), 32'h0);
        tick(); peek(0); lit("rst_pend", rdata, 32'h0);
        tick(); peek(1); lit("rst_mask", rdata, 32'h0);
        tick(); peek(2); lit("rst_mode", rdata, 32'h0);

        // Randomized traffic
        wr(1, 32'hF);
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) src_irq[i] = ~src_irq[i];
            end
            we      = ($urandom_range(3) == 0);
            addr    = 2'($urandom_range(3));
            wdata   = $urandom;
            cpu_ack = ($urandom_range(2) == 0);
            reset   = ($urandom_range(599) == 0);
            if (we) $display("wr addr=%0d data=%h", addr, wdata);
            tick();
        end
        reset = 1'b0; we = 1'b0; cpu_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: src_irq  input  4  peripheral interrupt lines, source 0 highest priority.
REQ-004 SHALL have port: we  input  1  bus write strobe.
REQ-005 SHALL have port: addr  input  2  register select: 0 PEND, 1 MASK, 2 MODE, 3 CLAIM/EOI.
REQ-006 SHALL have port: wdata  input  32  bus write data; bits [3:0] used.
REQ-007 SHALL have port: rdata  output  32  combinational read of addressed register.
REQ-008 SHALL have port: cpu_ack  input  1  one-cycle pulse: CP0 has taken the interrupt.
REQ-009 SHALL have port: hwint  output  6  to CP0; hwint[id+2] high for the granted source; hwint[1:0] always 0.
REQ-010 SHALL have port: irq_id  output  2  id of current granted source; 0 when IDLE.

Function
REQ-011 SHALL keep MASK[3:0] (1 = enabled) and MODE[3:0] (1 = edge, 0 = level), both read/write, upper bits read 0.
REQ-012 SHALL sample src_irq into a register each cycle; edge source i detected when sampled prev 0 and current 1.
REQ-013 SHALL set PEND[i] on detected edge (edge mode) or every cycle src_irq[i]=1 (level mode), regardless of MASK.
REQ-014 SHALL clear PEND bits by write to addr 0 with wdata bit = 1 (write-1-to-clear); set and clear in same cycle -> set wins.
REQ-015 SHALL implement FSM states IDLE, ASSERT, SERVICE.
REQ-016 IDLE: when (PEND & MASK) != 0, latch lowest-index set bit as id, next state ASSERT.
REQ-017 ASSERT: hwint[id+2]=1; cpu_ack -> SERVICE; if MASK[id] or PEND[id] becomes 0 -> IDLE (hwint low next cycle).
REQ-018 SERVICE: hwint=0; write to addr 3 (EOI) clears PEND[id] (unless re-set same cycle) and -> IDLE.
REQ-019 EOI write outside SERVICE SHALL be ignored; cpu_ack outside ASSERT SHALL be ignored.
REQ-020 Latency: PEND bit set at edge N -> state ASSERT and hwint high after edge N+1.
REQ-021 Read addr 3 SHALL return {28'b0, state[1:0], id[1:0]}... encoded as bits [3:2] state (0 IDLE,1 ASSERT,2 SERVICE), [1:0] id.
REQ-022 SHALL not preempt: higher-priority pend during ASSERT/SERVICE waits until IDLE.
REQ-023 After EOI, re-arbitration SHALL occur in IDLE on the following cycle (one idle cycle minimum between grants).
REQ-024 hwint and irq_id SHALL be driven from registered state only (no combinational path from src_irq).

Reset
REQ-025 reset SHALL force state IDLE, PEND=0, MASK=0, MODE=0, sampled src=0, hwint=0, irq_id=0, including mid-ASSERT/SERVICE.
REQ-026 First cycle after reset SHALL treat src_irq already high in edge mode as no edge.

Verification
REQ-027 MASK=0xF, MODE=0, src_irq=4'b0100 held -> hwint=6'b010000 two cycles later, irq_id=2.
REQ-028 MASK=0xF, PEND gets 4'b1010 same cycle -> id=1 granted; after cpu_ack and EOI, id=3 granted; hwint=6'b100000.
REQ-029 MODE=0x1, src_irq[0] pulse one cycle -> PEND=0x1; without pulse repeat, after ack+EOI PEND=0, FSM stays IDLE.
REQ-030 ASSERT on id 2, write MASK=0x0 -> hwint=0 next cycle, state IDLE, PEND[2] still 1.
REQ-031 SERVICE on id 0, EOI write same cycle as src_irq[0] edge (edge mode) -> PEND[0] stays 1, new grant id 0 after IDLE cycle.
REQ-032 reset asserted in SERVICE -> next cycle rdata(addr 3)=0, hwint=0, PEND=MASK=MODE=0.
